// File: rtl/iis_read_logic.sv
// I2S receiver: oversamples bclk/lrclk/sdata_i in the clk_100m domain and deserialises
// MSB-first, one-bclk-delayed left/right words into a parallel pair with a valid strobe.
// Optional feature: define IIS_RX_FRAME_ERR_EN to enable the frame_err_o pulse on a
// truncated word; without it frame_err_o is tied low and recovery is unchanged.
module iis_read_logic #(
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk_100m,
  input  logic              rst,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sdata_i,
  input  logic              en,
  output logic [DATA_W-1:0] ldata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              valid_o,
  output logic              frame_err_o
);

`ifdef IIS_RX_FRAME_ERR_EN
  localparam bit FrameErrEn = 1'b1;
`else
  localparam bit FrameErrEn = 1'b0;
`endif

  localparam logic [4:0] CntLast = 5'(DATA_W);

  typedef enum logic [4:0] {
    StIdle      = 5'b00001,
    StWaitLeft  = 5'b00010,
    StRecvLeft  = 5'b00100,
    StWaitRight = 5'b01000,
    StRecvRight = 5'b10000
  } state_e;

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shadow_q;
  logic              pair_ok_q;

  // [0],[1] synchroniser, [2] edge-detect delay; data needs only the sync stage so that
  // its sample lines up with the bclk rise event
  logic [2:0] bclk_q;
  logic [2:0] lrclk_q;
  logic [1:0] sdata_q;

  logic              bclk_rise;
  logic              left_start;
  logic              right_start;
  logic              bit_evt;
  logic [DATA_W-1:0] word_next;

  // Synchronise the asynchronous I2S pins
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      bclk_q  <= '0;
      lrclk_q <= '0;
      sdata_q <= '0;
    end else begin
      bclk_q  <= {bclk_q[1:0], bclk};
      lrclk_q <= {lrclk_q[1:0], lrclk};
      sdata_q <= {sdata_q[0], sdata_i};
    end
  end

  // Edge events; an lrclk edge in the same cycle suppresses the bit event
  always_comb begin
    bclk_rise   = bclk_q[1] & ~bclk_q[2];
    left_start  = ~lrclk_q[1] & lrclk_q[2];
    right_start = lrclk_q[1] & ~lrclk_q[2];
    bit_evt     = bclk_rise & ~(left_start | right_start);
    word_next   = {shift_q[DATA_W-2:0], sdata_q[1]};
  end

  // Receive FSM with bit counter, shift register, shadow and registered outputs
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      shadow_q    <= '0;
      pair_ok_q   <= 1'b0;
      ldata_o     <= '0;
      rdata_o     <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      if (!en) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        shift_q   <= '0;
        shadow_q  <= '0;
        pair_ok_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StWaitLeft;

          // right_start is ignored so a stream always locks on a left word first
          StWaitLeft: begin
            if (left_start) begin
              state_q   <= StRecvLeft;
              cnt_q     <= '0;
              shift_q   <= '0;
              pair_ok_q <= 1'b0;
            end
          end

          StRecvLeft: begin
            if (right_start) begin
              // Truncated left word: abandon the pair, still track the right slot
              state_q     <= StRecvRight;
              cnt_q       <= '0;
              shift_q     <= '0;
              pair_ok_q   <= 1'b0;
              frame_err_o <= FrameErrEn && (cnt_q != '0);
            end else if (bit_evt) begin
              if (cnt_q != '0) shift_q <= word_next;
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == CntLast) begin
                shadow_q  <= word_next;
                pair_ok_q <= 1'b1;
                cnt_q     <= '0;
                state_q   <= StWaitRight;
              end
            end
          end

          StWaitRight: begin
            if (right_start) begin
              state_q <= StRecvRight;
              cnt_q   <= '0;
              shift_q <= '0;
            end
          end

          StRecvRight: begin
            if (left_start) begin
              state_q     <= StRecvLeft;
              cnt_q       <= '0;
              shift_q     <= '0;
              pair_ok_q   <= 1'b0;
              frame_err_o <= FrameErrEn && (cnt_q != '0);
            end else if (bit_evt) begin
              if (cnt_q != '0) shift_q <= word_next;
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == CntLast) begin
                // Only a pair whose left word completed cleanly is published
                if (pair_ok_q) begin
                  rdata_o <= word_next;
                  ldata_o <= shadow_q;
                  valid_o <= 1'b1;
                end
                pair_ok_q <= 1'b0;
                cnt_q     <= '0;
                state_q   <= StWaitLeft;
              end
            end
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iis_read_logic.sv
// Self-checking bench for iis_read_logic: drives I2S slots with random words/pad bits and
// compares the published pairs and frame-error pulses with a slot-level model.
module tb_iis_read_logic;

`ifdef IIS_RX_FRAME_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk_100m = 1'b0;
  logic        rst, bclk, lrclk, sdata_i, en;
  logic [23:0] ldata_o, rdata_o;
  logic        valid_o, frame_err_o;

  int tests_run = 0;
  int tests_failed = 0;
  int half_p = 16;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  int          err_obs = 0;
  int          err_exp = 0;

  // Slot-level model state
  bit          m_in_stream, m_have_left, m_prev_short;
  logic [23:0] m_left;
  logic [47:0] last_pair = '0;

  always #5 clk_100m = ~clk_100m;

  iis_read_logic #(.DATA_W(24)) dut (
    .clk_100m   (clk_100m),
    .rst        (rst),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata_i    (sdata_i),
    .en         (en),
    .ldata_o    (ldata_o),
    .rdata_o    (rdata_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o)
  );

  // Observe every strobe cycle; a stretched pulse shows up as an extra entry
  always @(negedge clk_100m) begin
    if (valid_o) obs_q.push_back({ldata_o, rdata_o});
    if (frame_err_o) err_obs++;
  end

  task automatic model_disable();
    m_in_stream  = 1'b0;
    m_have_left  = 1'b0;
    m_prev_short = 1'b0;
  endtask

  // A pair is published only for a full left slot directly followed by a full right slot,
  // both started while enabled; a short slot ended by the next edge is a frame error
  task automatic model_slot(input logic lr, input logic [23:0] w, input int n);
    bit full;
    full = (n >= 25);
    if (!en) begin
      model_disable();
    end else if (lr == 1'b0) begin
      if (m_prev_short && ErrEn) err_exp++;
      m_in_stream  = 1'b1;
      m_have_left  = full;
      m_left       = w;
      m_prev_short = !full;
    end else if (m_in_stream) begin
      if (m_prev_short && ErrEn) err_exp++;
      if (full && m_have_left) begin
        exp_q.push_back({m_left, w});
        last_pair = {m_left, w};
      end
      m_have_left  = 1'b0;
      m_prev_short = !full;
    end else begin
      m_prev_short = 1'b0;
    end
  endtask

  // Bit i of a slot: bit 0 is the delay slot, bits 1..24 carry the word MSB first
  task automatic send_bits(input logic lr, input logic [23:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bclk = 1'b0;
      if (i == 0) lrclk = lr;
      sdata_i = (i >= 1 && i <= 24) ? w[24-i] : 1'($urandom);
      repeat (half_p) @(negedge clk_100m);
      bclk = 1'b1;
      repeat (half_p) @(negedge clk_100m);
    end
  endtask

  task automatic slot(input logic lr, input logic [23:0] w, input int n);
    model_slot(lr, w, n);
    send_bits(lr, w, 0, n);
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    obs_q.delete();
    err_obs = 0;
    err_exp = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; bclk = 1'b1; lrclk = 1'b1; sdata_i = 1'b0;
    model_disable();
    repeat (3) @(negedge clk_100m);
    tests_run++;
    if (ldata_o !== 24'h0) begin
      tests_failed++; $display("FAIL reset_ldata got %h want 000000", ldata_o);
    end
    tests_run++;
    if (rdata_o !== 24'h0) begin
      tests_failed++; $display("FAIL reset_rdata got %h want 000000", rdata_o);
    end
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got %b want 0", valid_o);
    end
    tests_run++;
    if (frame_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_frame_err got %b want 0", frame_err_o);
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (10) @(negedge clk_100m);
  endtask

  task automatic test_normal_pair();
    clear_scoreboard();
    half_p = 16;
    slot(1'b0, 24'hA5A5A5, 33);
    slot(1'b1, 24'h5A5A5A, 33);
    repeat (10) @(negedge clk_100m);
    tests_run++;
    if (obs_q.size() !== 1) begin
      tests_failed++; $display("FAIL normal_count got %0d want 1", obs_q.size());
    end
    tests_run++;
    if (obs_q.size() < 1 || obs_q[0] !== 48'hA5A5A5_5A5A5A) begin
      tests_failed++;
      $display("FAIL normal_pair got %h want a5a5a55a5a5a", obs_q.size() ? obs_q[0] : 48'h0);
    end
    tests_run++;
    if (err_obs !== 0) begin
      tests_failed++; $display("FAIL normal_frame_err got %0d want 0", err_obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] l, r;
    clear_scoreboard();
    slot(1'b0, 24'h800001, 32);
    slot(1'b1, 24'h7FFFFE, 32);
    slot(1'b0, 24'hFFFFFF, 32);
    slot(1'b1, 24'h000000, 32);
    for (int p = 0; p < 3; p++) begin
      half_p = $urandom_range(16, 4);
      l = 24'($urandom);
      r = 24'($urandom);
      slot(1'b0, l, $urandom_range(34, 25));
      slot(1'b1, r, $urandom_range(34, 25));
    end
    repeat (10) @(negedge clk_100m);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++; $display("FAIL b2b_pair%0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (err_obs !== 0) begin
      tests_failed++; $display("FAIL b2b_frame_err got %0d want 0", err_obs);
    end
  endtask

  task automatic test_short_frame();
    clear_scoreboard();
    half_p = $urandom_range(16, 4);
    slot(1'b0, 24'($urandom), 11);
    slot(1'b1, 24'h123456, 32);
    slot(1'b0, 24'h111111, 32);
    slot(1'b1, 24'h222222, 32);
    repeat (10) @(negedge clk_100m);
    tests_run++;
    if (obs_q.size() !== 1) begin
      tests_failed++; $display("FAIL short_count got %0d want 1", obs_q.size());
    end
    tests_run++;
    if (obs_q.size() < 1 || obs_q[0] !== 48'h111111_222222) begin
      tests_failed++;
      $display("FAIL short_pair got %h want 111111222222", obs_q.size() ? obs_q[0] : 48'h0);
    end
    tests_run++;
    if (err_obs !== err_exp) begin
      tests_failed++; $display("FAIL short_frame_err got %0d want %0d", err_obs, err_exp);
    end
  endtask

  task automatic test_en_drop();
    logic [23:0] w;
    clear_scoreboard();
    half_p = $urandom_range(16, 4);
    w = 24'($urandom);
    model_slot(1'b0, w, 13);
    send_bits(1'b0, w, 0, 13);
    en = 1'b0;
    model_disable();
    repeat (3) @(negedge clk_100m);
    tests_run++;
    if (ldata_o !== last_pair[47:24]) begin
      tests_failed++; $display("FAIL endrop_ldata_hold got %h want %h", ldata_o, last_pair[47:24]);
    end
    tests_run++;
    if (rdata_o !== last_pair[23:0]) begin
      tests_failed++; $display("FAIL endrop_rdata_hold got %h want %h", rdata_o, last_pair[23:0]);
    end
    send_bits(1'b0, w, 13, 19);
    en = 1'b1;
    repeat (4) @(negedge clk_100m);
    slot(1'b1, 24'($urandom), 32);
    slot(1'b0, 24'($urandom), 32);
    slot(1'b1, 24'($urandom), 32);
    repeat (10) @(negedge clk_100m);
    tests_run++;
    if (obs_q.size() !== exp_q.size() || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL endrop_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++; $display("FAIL endrop_pair%0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (err_obs !== 0) begin
      tests_failed++; $display("FAIL endrop_frame_err got %0d want 0", err_obs);
    end
  endtask

  task automatic test_start_mid_frame();
    logic [23:0] w;
    clear_scoreboard();
    half_p = $urandom_range(16, 4);
    en = 1'b0;
    repeat (4) @(negedge clk_100m);
    slot(1'b0, 24'($urandom), 32);
    w = 24'($urandom);
    model_slot(1'b1, w, 10);
    send_bits(1'b1, w, 0, 10);
    en = 1'b1;
    send_bits(1'b1, w, 10, 22);
    slot(1'b0, 24'($urandom), 32);
    slot(1'b1, 24'($urandom), 32);
    repeat (10) @(negedge clk_100m);
    tests_run++;
    if (obs_q.size() !== exp_q.size() || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL midstart_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++; $display("FAIL midstart_pair%0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (err_obs !== 0) begin
      tests_failed++; $display("FAIL midstart_frame_err got %0d want 0", err_obs);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] w;
    clear_scoreboard();
    half_p = $urandom_range(16, 4);
    slot(1'b0, 24'($urandom), 32);
    w = 24'($urandom);
    send_bits(1'b1, w, 0, 21);
    rst = 1'b1;
    model_disable();
    #1;
    tests_run++;
    if ({ldata_o, rdata_o} !== 48'h0) begin
      tests_failed++; $display("FAIL rstmid_data got %h want 0", {ldata_o, rdata_o});
    end
    tests_run++;
    if ({valid_o, frame_err_o} !== 2'b00) begin
      tests_failed++; $display("FAIL rstmid_strobes got %b want 00", {valid_o, frame_err_o});
    end
    @(negedge clk_100m);
    rst = 1'b0;
    send_bits(1'b1, w, 21, 11);
    slot(1'b0, 24'($urandom), 32);
    slot(1'b1, 24'($urandom), 32);
    repeat (10) @(negedge clk_100m);
    tests_run++;
    if (obs_q.size() !== exp_q.size() || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++; $display("FAIL rstmid_pair%0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (err_obs !== 0) begin
      tests_failed++; $display("FAIL rstmid_frame_err got %0d want 0", err_obs);
    end
  endtask

  initial begin
    test_reset();
    test_normal_pair();
    test_back_to_back();
    test_short_frame();
    test_en_drop();
    test_start_mid_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
